mmio_arbiter: RTL and testbench
===============================

Name: mmio_arbiter

Overview:
- Two-master arbiter that shares the single mmio load/store port between the CPU data port (master 0) and a secondary bus master (master 1, e.g. boot loader or DMA engine).
- Sits between the requesters and mmio. Owns the request/grant handshake, round-robin fairness, command hold timing and read-data capture.
- Guarantees exactly one mmio store pulse and exactly one keyboard-pop load per transaction.

Parameters:
RD_LATENCY, 0, extra cycles the mmio command is held before read data is sampled (total hold = RD_LATENCY+1 cycles)
KBD_ADDR, 32'hfbadbeef, destructive-read address; load for it is asserted only in the final hold cycle

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
m0_req  input  1  master 0 request; level, held until m0_ack
m0_load  input  1  master 0 read
m0_store  input  1  master 0 write
m0_access  input  3  master 0 funct3 size/sign code
m0_addr  input  32  master 0 address
m0_wdata  input  32  master 0 write data
m0_ack  output  1  one-cycle completion pulse
m0_rdata  output  32  read data, valid while m0_ack=1
m1_req, m1_load, m1_store, m1_access, m1_addr, m1_wdata  inputs  1/1/1/3/32/32  master 1, same meaning
m1_ack  output  1  master 1 completion pulse
m1_rdata  output  32  master 1 read data
mmio_load  output  1  to mmio load
mmio_store  output  1  to mmio store
mmio_access  output  3  to mmio access
mmio_addr  output  32  to mmio addr
mmio_wdata  output  32  to mmio data_in
mmio_rdata  input  32  from mmio data_out (combinational)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE; all mmio_* outputs 0; m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; last_grant=1, so master 0 wins the first tie; hold counter=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No requests: stay in IDLE; mmio_load=mmio_store=0.
  - Exactly one req: grant it.
  - Both req: grant the master not equal to last_grant.
  - On grant: latch the granted master's load/store/access/addr/wdata into command registers; set last_grant; counter=RD_LATENCY; go to BUSY next cycle.
- BUSY:
  - mmio_access, mmio_addr and mmio_wdata are driven from the command registers and stay stable for all RD_LATENCY+1 cycles.
  - mmio_store=cmd_store only in the first BUSY cycle.
  - mmio_load=cmd_load in every BUSY cycle, except when cmd_addr==KBD_ADDR. In that case it is asserted only in the last BUSY cycle, so the keyboard pops exactly once.
  - Counter decrements each cycle. In the cycle counter==0 (last): if cmd_load, register mmio_rdata into the granted master's rdata; go to RESP.
- RESP (one cycle):
  - Granted master's ack=1; other master's ack=0.
  - Stores return rdata=0.
  - Requests are not sampled. Next state is IDLE.
- Ack and rdata are registered outputs. rdata holds its value until the next completion for that master.
- Latency: grant sampled at edge t; BUSY occupies t+1 .. t+1+RD_LATENCY; ack at t+2+RD_LATENCY. Default is 2 cycles from req sample to ack.
- A requester must drop req, or present a new command, by the cycle after ack. A req still high in the IDLE cycle after RESP is treated as a new transaction.
- Command changes by a requester while it is granted are ignored, because the command is latched at grant.
- req with neither load nor store: full transaction runs, no mmio side effects, ack with rdata=0.
- load and store both set: store takes priority; mmio_load forced 0.
- Reset asserted in BUSY or RESP: abort immediately. No ack, no further mmio strobes, all outputs return to reset values the next cycle.
- Steady back-to-back requests from both masters alternate strictly: 0,1,0,1...

Test Plan:
- Single read: m0_req lw addr 0x100, mmio_rdata=32'hdeadbeef, RD_LATENCY=0 -> mmio_load high exactly 1 cycle; m0_ack 2 cycles after req sample; m0_rdata=32'hdeadbeef; m1_ack stays 0.
- Tie after reset: m0 and m1 both request in the same cycle -> m0 is served first; m1 granted in the IDLE cycle after m0's RESP; m1_ack exactly 3 cycles after m0_ack.
- Fairness: both reqs held high for 8 transactions -> grant order 0,1,0,1,0,1,0,1; no master starved.
- Store pulse and keyboard pop with RD_LATENCY=2:
  - m1 sb to 0xfbad0005 -> mmio_store high for exactly 1 cycle; addr and wdata stable for 3 cycles.
  - lbu at 32'hfbadbeef -> mmio_load high only in the 3rd BUSY cycle.
- Reset mid-BUSY: rst asserted in the first BUSY cycle of a store -> no ack; mmio_store=0 the following cycle; next m1 request (last_grant=1) after release is served normally.
- Conflicting command: load and store both set on m0 -> mmio_store pulses once; mmio_load never asserted; m0_rdata=0.

Source files
------------

// File: rtl/mmio_arbiter_if.sv
// Bundle of both requester ports and the shared mmio load/store port.
// Handshake: a master raises req with a stable command and keeps it high until a one-cycle ack;
// rdata is valid while ack is high, and req still high in the cycle after ack is a new transaction.
interface mmio_arbiter_if;
    logic        m0_req;
    logic        m0_load;
    logic        m0_store;
    logic [2:0]  m0_access;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_load;
    logic        m1_store;
    logic [2:0]  m1_access;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;

    logic        mmio_load;
    logic        mmio_store;
    logic [2:0]  mmio_access;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;

    modport slave (
        input  m0_req, m0_load, m0_store, m0_access, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_load, m1_store, m1_access, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output mmio_load, mmio_store, mmio_access, mmio_addr, mmio_wdata,
        input  mmio_rdata
    );

    modport master (
        output m0_req, m0_load, m0_store, m0_access, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_load, m1_store, m1_access, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  mmio_load, mmio_store, mmio_access, mmio_addr, mmio_wdata,
        output mmio_rdata
    );
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one mmio load/store port between two masters.
// Command is latched at grant and held RD_LATENCY+1 cycles; ack and rdata are registered.
module mmio_arbiter #(
    parameter int unsigned RD_LATENCY = 0,
    parameter logic [31:0] KBD_ADDR   = 32'hfbadbeef
) (
    input  logic       clk,
    input  logic       rst,
    mmio_arbiter_if.slave bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CW = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LATENCY);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        cmd_load_q, cmd_load_d;
    logic        cmd_store_q, cmd_store_d;
    logic [2:0]  cmd_access_q, cmd_access_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    logic        sel;
    logic        sel_load;
    logic        sel_store;
    logic        mmio_load;
    logic        mmio_store;
    logic [2:0]  mmio_access;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cmd_load_d   = cmd_load_q;
        cmd_store_d  = cmd_store_q;
        cmd_access_d = cmd_access_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cnt_d        = cnt_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        mmio_load    = 1'b0;
        mmio_store   = 1'b0;
        mmio_access  = 3'b000;
        mmio_addr    = 32'h0;
        mmio_wdata   = 32'h0;
        // On a tie, master 1 wins only if master 0 was served last.
        sel          = bus.m1_req & (~bus.m0_req | ~last_grant_q);
        sel_load     = sel ? bus.m1_load  : bus.m0_load;
        sel_store    = sel ? bus.m1_store : bus.m0_store;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    cmd_store_d  = sel_store;
                    cmd_load_d   = sel_load & ~sel_store;
                    cmd_access_d = sel ? bus.m1_access : bus.m0_access;
                    cmd_addr_d   = sel ? bus.m1_addr   : bus.m0_addr;
                    cmd_wdata_d  = sel ? bus.m1_wdata  : bus.m0_wdata;
                    cnt_d        = CNT_INIT;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                mmio_access = cmd_access_q;
                mmio_addr   = cmd_addr_q;
                mmio_wdata  = cmd_wdata_q;
                mmio_store  = cmd_store_q && (cnt_q == CNT_INIT);
                // The keyboard read pops its FIFO, so strobe it only once, in the sampling cycle.
                mmio_load   = cmd_load_q && ((cmd_addr_q != KBD_ADDR) || (cnt_q == '0));
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (grant_q) begin
                        m1_ack_d   = 1'b1;
                        m1_rdata_d = cmd_load_q ? bus.mmio_rdata : 32'h0;
                    end else begin
                        m0_ack_d   = 1'b1;
                        m0_rdata_d = cmd_load_q ? bus.mmio_rdata : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cmd_load_q   <= 1'b0;
            cmd_store_q  <= 1'b0;
            cmd_access_q <= 3'b000;
            cmd_addr_q   <= 32'h0;
            cmd_wdata_q  <= 32'h0;
            cnt_q        <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= 32'h0;
            m1_rdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cmd_load_q   <= cmd_load_d;
            cmd_store_q  <= cmd_store_d;
            cmd_access_q <= cmd_access_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cnt_q        <= cnt_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign bus.m0_ack      = m0_ack_q;
    assign bus.m1_ack      = m1_ack_q;
    assign bus.m0_rdata    = m0_rdata_q;
    assign bus.m1_rdata    = m1_rdata_q;
    assign bus.mmio_load   = mmio_load;
    assign bus.mmio_store  = mmio_store;
    assign bus.mmio_access = mmio_access;
    assign bus.mmio_addr   = mmio_addr;
    assign bus.mmio_wdata  = mmio_wdata;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: instance 0 uses RD_LATENCY=0, instance 1 uses RD_LATENCY=2.
// Expected acks are queued per instance and popped by a monitor whenever an ack appears.
module tb_mmio_arbiter;
    localparam logic [31:0] KBD = 32'hfbadbeef;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus, indexed [instance][master]
    logic        rst_v  [2];
    logic        req_v  [2][2];
    logic        ld_v   [2][2];
    logic        st_v   [2][2];
    logic [2:0]  acc_v  [2][2];
    logic [31:0] addr_v [2][2];
    logic [31:0] wd_v   [2][2];
    logic [31:0] mrd_v  [2];

    // observed outputs
    logic        ack_v  [2][2];
    logic [31:0] rdat_v [2][2];
    logic        mld    [2];
    logic        mst    [2];
    logic [2:0]  macc   [2];
    logic [31:0] maddr  [2];
    logic [31:0] mwd    [2];
    logic [1:0]  dbg    [2];

    mmio_arbiter_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].m0_req     = req_v[g][0];
        assign bus[g].m0_load    = ld_v[g][0];
        assign bus[g].m0_store   = st_v[g][0];
        assign bus[g].m0_access  = acc_v[g][0];
        assign bus[g].m0_addr    = addr_v[g][0];
        assign bus[g].m0_wdata   = wd_v[g][0];
        assign bus[g].m1_req     = req_v[g][1];
        assign bus[g].m1_load    = ld_v[g][1];
        assign bus[g].m1_store   = st_v[g][1];
        assign bus[g].m1_access  = acc_v[g][1];
        assign bus[g].m1_addr    = addr_v[g][1];
        assign bus[g].m1_wdata   = wd_v[g][1];
        assign bus[g].mmio_rdata = mrd_v[g];
        assign ack_v[g][0]  = bus[g].m0_ack;
        assign ack_v[g][1]  = bus[g].m1_ack;
        assign rdat_v[g][0] = bus[g].m0_rdata;
        assign rdat_v[g][1] = bus[g].m1_rdata;
        assign mld[g]       = bus[g].mmio_load;
        assign mst[g]       = bus[g].mmio_store;
        assign macc[g]      = bus[g].mmio_access;
        assign maddr[g]     = bus[g].mmio_addr;
        assign mwd[g]       = bus[g].mmio_wdata;

        mmio_arbiter #(
            .RD_LATENCY((g == 0) ? 0 : 2),
            .KBD_ADDR  (KBD)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_v[g]),
            .bus      (bus[g]),
            .dbg_state(dbg[g])
        );
    end

    // scoreboard: {master, rdata}
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int n_cmp = 0;
    int n_bad = 0;
    int st_cnt [2];
    int ld_cnt [2];
    int st_cyc [2];
    int ld_cyc [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int d, input int m, input logic [31:0] rd);
        logic [32:0] e;
        e = {(m == 1), rd};
        if (d == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic monitor();
        logic [32:0] e;
        logic        empty;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mst[d]) begin st_cnt[d]++; st_cyc[d] = cyc; end
                if (mld[d]) begin ld_cnt[d]++; ld_cyc[d] = cyc; end
                if (ack_v[d][0] || ack_v[d][1]) begin
                    empty = 1'b0;
                    e = '0;
                    if (d == 0) begin
                        if (exp_q0.size() == 0) empty = 1'b1; else e = exp_q0.pop_front();
                    end else begin
                        if (exp_q1.size() == 0) empty = 1'b1; else e = exp_q1.pop_front();
                    end
                    if (empty) begin
                        check("unexpected_ack", 32'(d), 32'hffffffff);
                    end else begin
                        check("ack_master", {30'd0, ack_v[d][1], ack_v[d][0]},
                              e[32] ? 32'd2 : 32'd1);
                        check("ack_rdata", rdat_v[d][e[32]], e[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic set_cmd(input int d, input int m, input logic ld, input logic st,
                           input logic [2:0] acc, input logic [31:0] addr, input logic [31:0] wd);
        req_v[d][m]  = 1'b1;
        ld_v[d][m]   = ld;
        st_v[d][m]   = st;
        acc_v[d][m]  = acc;
        addr_v[d][m] = addr;
        wd_v[d][m]   = wd;
    endtask

    task automatic drop(input int d, input int m);
        req_v[d][m]  = 1'b0;
        ld_v[d][m]   = 1'b0;
        st_v[d][m]   = 1'b0;
        acc_v[d][m]  = 3'b000;
        addr_v[d][m] = 32'h0;
        wd_v[d][m]   = 32'h0;
    endtask

    // Waits (bounded) for this master's ack, then withdraws its request before the next IDLE sample.
    task automatic wait_ack(input int d, input int m, output int ac);
        ac = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ack_v[d][m]) begin
                ac = cyc;
                break;
            end
        end
        if (ac < 0) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        drop(d, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, a0, a1, s0, l0, n;
        fork
            monitor();
        join_none
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1;
            mrd_v[d] = 32'h0;
            st_cnt[d] = 0; ld_cnt[d] = 0; st_cyc[d] = 0; ld_cyc[d] = 0;
            for (int m = 0; m < 2; m++) drop(d, m);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;

        // reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_state", 32'(dbg[d]), 32'd0);
            check("rst_mmio_ctl", {29'd0, mld[d], mst[d], 1'b0}, 32'd0);
            check("rst_mmio_addr", maddr[d], 32'h0);
            check("rst_mmio_wdata", mwd[d] | {29'd0, macc[d]}, 32'h0);
            check("rst_acks", {30'd0, ack_v[d][1], ack_v[d][0]}, 32'd0);
            check("rst_rdata", rdat_v[d][0] | rdat_v[d][1], 32'h0);
        end

        // tie after reset (latency 0): m0 first, m1 three cycles later
        mrd_v[0] = 32'h12345678;
        @(posedge clk); #1;
        set_cmd(0, 0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        set_cmd(0, 1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        push_exp(0, 0, 32'h12345678);
        push_exp(0, 1, 32'h12345678);
        c = cyc;
        wait_ack(0, 0, a0);
        wait_ack(0, 1, a1);
        check("tie_m0_latency", 32'(a0 - c), 32'd2);
        check("tie_m1_gap", 32'(a1 - a0), 32'd3);

        // single read
        mrd_v[0] = 32'hdeadbeef;
        @(posedge clk); #1;
        set_cmd(0, 0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        push_exp(0, 0, 32'hdeadbeef);
        c = cyc; l0 = ld_cnt[0];
        wait_ack(0, 0, a0);
        check("read_latency", 32'(a0 - c), 32'd2);
        check("read_load_cycles", 32'(ld_cnt[0] - l0), 32'd1);

        // load+store together: store wins, rdata 0
        mrd_v[0] = 32'hcafef00d;
        @(posedge clk); #1;
        set_cmd(0, 0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h55);
        push_exp(0, 0, 32'h0);
        s0 = st_cnt[0]; l0 = ld_cnt[0];
        wait_ack(0, 0, a0);
        check("conflict_store_cycles", 32'(st_cnt[0] - s0), 32'd1);
        check("conflict_load_cycles", 32'(ld_cnt[0] - l0), 32'd0);

        // fairness: m0 was served last, so the order is 1,0,1,0,...
        @(posedge clk); #1;
        set_cmd(0, 0, 1'b0, 1'b1, 3'b010, 32'h500, 32'h11);
        set_cmd(0, 1, 1'b0, 1'b1, 3'b010, 32'h600, 32'h22);
        for (int i = 0; i < 8; i++) push_exp(0, (i % 2 == 0) ? 1 : 0, 32'h0);
        s0 = st_cnt[0];
        n = 0;
        for (int k = 0; k < 60 && n < 8; k++) begin
            @(negedge clk);
            if (ack_v[0][0] || ack_v[0][1]) n++;
        end
        @(posedge clk); #1;
        drop(0, 0);
        drop(0, 1);
        check("fair_acks", 32'(n), 32'd8);
        check("fair_store_cycles", 32'(st_cnt[0] - s0), 32'd8);

        // request with neither load nor store
        @(posedge clk); #1;
        set_cmd(0, 1, 1'b0, 1'b0, 3'b010, 32'h300, 32'h77);
        push_exp(0, 1, 32'h0);
        c = cyc; s0 = st_cnt[0]; l0 = ld_cnt[0];
        wait_ack(0, 1, a1);
        check("nop_latency", 32'(a1 - c), 32'd2);
        check("nop_strobes", 32'((st_cnt[0] - s0) + (ld_cnt[0] - l0)), 32'd0);

        // latency 2: m1 sb, store pulses once, addr/wdata stable for three cycles
        @(posedge clk); #1;
        set_cmd(1, 1, 1'b0, 1'b1, 3'b000, 32'hfbad0005, 32'h000000a5);
        push_exp(1, 1, 32'h0);
        c = cyc; s0 = st_cnt[1];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("sb_addr", maddr[1], 32'hfbad0005);
            check("sb_wdata", mwd[1], 32'h000000a5);
        end
        wait_ack(1, 1, a1);
        check("sb_latency", 32'(a1 - c), 32'd4);
        check("sb_store_cycles", 32'(st_cnt[1] - s0), 32'd1);
        check("sb_store_first_busy", 32'(st_cyc[1] - c), 32'd1);

        // keyboard lbu: load only in the third BUSY cycle
        mrd_v[1] = 32'h00000041;
        @(posedge clk); #1;
        set_cmd(1, 0, 1'b1, 1'b0, 3'b100, KBD, 32'h0);
        push_exp(1, 0, 32'h00000041);
        c = cyc; l0 = ld_cnt[1];
        wait_ack(1, 0, a0);
        check("kbd_load_cycles", 32'(ld_cnt[1] - l0), 32'd1);
        check("kbd_load_last_busy", 32'(ld_cyc[1] - c), 32'd3);

        // ordinary load holds mmio_load for all three BUSY cycles
        mrd_v[1] = 32'h00000077;
        @(posedge clk); #1;
        set_cmd(1, 1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        push_exp(1, 1, 32'h00000077);
        l0 = ld_cnt[1];
        wait_ack(1, 1, a1);
        check("lw_load_cycles", 32'(ld_cnt[1] - l0), 32'd3);

        // reset in the first BUSY cycle of an m0 store
        @(posedge clk); #1;
        set_cmd(1, 0, 1'b0, 1'b1, 3'b010, 32'h400, 32'h99);
        @(posedge clk); #1;
        rst_v[1] = 1'b1;
        drop(1, 0);
        @(negedge clk);
        check("rst_busy_store_seen", 32'(mst[1]), 32'd1);
        @(posedge clk); #1;
        rst_v[1] = 1'b0;
        @(negedge clk);
        check("rst_abort_store", 32'(mst[1]), 32'd0);
        check("rst_abort_state", 32'(dbg[1]), 32'd0);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_v[1][0] || ack_v[1][1]) n++;
        end
        check("rst_no_ack", 32'(n), 32'd0);

        // tie after mid-transaction reset: m0 first again, then m1 served normally
        mrd_v[1] = 32'h00005a5a;
        @(posedge clk); #1;
        set_cmd(1, 0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        set_cmd(1, 1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        push_exp(1, 0, 32'h00005a5a);
        push_exp(1, 1, 32'h00005a5a);
        c = cyc;
        wait_ack(1, 0, a0);
        wait_ack(1, 1, a1);
        check("post_rst_m0_latency", 32'(a0 - c), 32'd4);
        check("post_rst_m1_gap", 32'(a1 - a0), 32'd5);

        repeat (3) @(negedge clk);
        check("scoreboard_drained_0", 32'(exp_q0.size()), 32'd0);
        check("scoreboard_drained_1", 32'(exp_q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
